// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and 50 MHz refclk timing defaults for the PLL reset/lock
// sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAULT
    } pll_state_e;

    localparam int DEF_RST_HOLD_CYCLES     = 100;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 16;

    // Width of a counter able to hold 0..max_retries (never narrower than 1).
    function automatic int retry_w(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    localparam int DEF_RETRY_W = retry_w(DEF_MAX_RETRIES);

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-facing and system-facing signals of the reset sequencer.
// master = sequencer side, slave = PLL wrapper / system side.
interface pll_reset_ctrl_if
    import pll_ctrl_pkg::*;
#(
    parameter int RETRY_W = DEF_RETRY_W
);
    logic               pll_locked;
    logic               relock_req;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt
    );
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for a PLL lock indication, synchronous reset to 0.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: hold, wait for lock with timeout/retry, qualify lock
// stability, then release the downstream reset.
//
//   state         | meaning
//   RESET_HOLD    | PLL held in reset for RST_HOLD_CYCLES
//   WAIT_LOCK     | PLL released, waiting for lock (timeout -> retry/fault)
//   STABILIZE     | lock seen, must stay high LOCK_STABLE_CYCLES
//   RUN           | locked and stable, downstream reset released
//   FAULT         | retries exhausted, waits for relock_req
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    pll_reset_ctrl_if.master bus
);
    localparam int RETRY_W = retry_w(MAX_RETRIES);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_d;
    logic               pll_rst_q, sys_rst_q, ready_q, fault_q, lock_lost_q;
    logic               locked_s;

    pll_lock_sync u_lock_sync (
        .clk_i   (refclk),
        .rst_i   (rst),
        .async_i (bus.pll_locked),
        .sync_o  (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            ST_RESET_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RESET_HOLD;
                    end
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) state_d = ST_WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Lock loss wins over a simultaneous relock_req but both take the same path.
                if (!locked_s || bus.relock_req) begin
                    state_d = ST_RESET_HOLD;
                    lost_d  = !locked_s;
                end
            end
            ST_FAULT: begin
                if (bus.relock_req) begin
                    state_d = ST_RESET_HOLD;
                    retry_d = '0;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == ST_RUN) retry_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_RESET_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_RESET_HOLD) || (state_d == ST_FAULT);
            sys_rst_q   <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
            lock_lost_q <= lost_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: per-cycle comparison against a
// phase/age model plus hand-computed latency and count expectations.
module tb_pll_reset_ctrl;
    import pll_ctrl_pkg::*;

    localparam int HOLD_N = 4;
    localparam int TO_N   = 16;
    localparam int STAB_N = 8;
    localparam int MAXR   = 2;

    localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;
    localparam int S_PLL_RST = 0, S_SYS_RST = 1, S_READY = 2, S_FAULT = 3, S_LOST = 4;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_reset_ctrl_if #(.RETRY_W(retry_w(MAXR))) bus ();

    pll_reset_ctrl #(
        .RST_HOLD_CYCLES     (HOLD_N),
        .LOCK_TIMEOUT_CYCLES (TO_N),
        .LOCK_STABLE_CYCLES  (STAB_N),
        .MAX_RETRIES         (MAXR),
        .CNT_W               (16)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: which phase we are in, how long we have been in it,
    // and the last two pll_locked samples.
    int   ph = P_HOLD, age = 0, tries = 0;
    logic sync1 = 1'b0, sync2 = 1'b0, m_lost = 1'b0, model_live = 1'b0;

    task automatic model_step();
        int   nxt;
        logic ls;
        if (rst) begin
            ph = P_HOLD; age = 0; tries = 0; sync1 = 1'b0; sync2 = 1'b0; m_lost = 1'b0;
        end else begin
            ls = sync2;
            nxt = ph;
            m_lost = 1'b0;
            case (ph)
                P_HOLD: if (age == HOLD_N - 1) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls) nxt = P_STAB;
                    else if (age == TO_N - 1) begin
                        if (tries == MAXR) nxt = P_FAULT;
                        else begin tries++; nxt = P_HOLD; end
                    end
                end
                P_STAB: if (!ls) nxt = P_WAIT; else if (age == STAB_N - 1) nxt = P_RUN;
                P_RUN: if (!ls || bus.relock_req) begin nxt = P_HOLD; m_lost = !ls; end
                default: if (bus.relock_req) nxt = P_HOLD;
            endcase
            if (nxt == P_RUN || (ph == P_FAULT && nxt == P_HOLD)) tries = 0;
            age = (nxt == ph) ? age + 1 : 0;
            ph = nxt;
            sync2 = sync1;
            sync1 = bus.pll_locked;
        end
        model_live = 1'b1;
    endtask

    initial forever begin
        @(posedge refclk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge refclk);
        if (model_live) begin
            cmp("pll_rst",   16'(bus.pll_rst),   16'(ph == P_HOLD || ph == P_FAULT));
            cmp("sys_rst",   16'(bus.sys_rst),   16'(ph != P_RUN));
            cmp("ready",     16'(bus.ready),     16'(ph == P_RUN));
            cmp("fault",     16'(bus.fault),     16'(ph == P_FAULT));
            cmp("lock_lost", 16'(bus.lock_lost), 16'(m_lost));
            cmp("retry_cnt", 16'(bus.retry_cnt), 16'(tries));
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            S_PLL_RST: return bus.pll_rst;
            S_SYS_RST: return bus.sys_rst;
            S_READY:   return bus.ready;
            S_FAULT:   return bus.fault;
            default:   return bus.lock_lost;
        endcase
    endfunction

    // Counts negedges until the selected output reaches val; expiry is a failure.
    task automatic wait_for(input int sel, input logic val, input int limit,
                            input string nm, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            @(negedge refclk);
            n++;
        end
        if (sig(sel) !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got %0d, expected %0d", nm, n, sig(sel), val);
        end
    endtask

    task automatic relock_pulse();
        bus.relock_req = 1'b1;
        @(negedge refclk);
        bus.relock_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n, n2, pulses, highs;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge refclk);
        cmp("rst_pll_rst", 16'(bus.pll_rst),   16'd1);
        cmp("rst_sys_rst", 16'(bus.sys_rst),   16'd1);
        cmp("rst_ready",   16'(bus.ready),     16'd0);
        cmp("rst_fault",   16'(bus.fault),     16'd0);
        cmp("rst_retry",   16'(bus.retry_cnt), 16'd0);

        // Normal lock: pll_locked rises 3 cycles after pll_rst falls.
        rst = 1'b0;
        wait_for(S_PLL_RST, 1'b0, 50, "hold_end", n);
        cmp("hold_len", 16'(n), 16'd4);
        repeat (2) @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_for(S_READY, 1'b1, 100, "first_ready", n2);
        cmp("first_ready_lat", 16'(n + 2 + n2), 16'd17);
        cmp("first_ready_retry", 16'(bus.retry_cnt), 16'd0);
        cmp("first_ready_sys_rst", 16'(bus.sys_rst), 16'd0);

        // Lock loss in RUN: one edge to sample the drop, then two sync flops.
        repeat (3) @(negedge refclk);
        bus.pll_locked = 1'b0;
        wait_for(S_READY, 1'b0, 20, "loss_drop", n);
        cmp("loss_lat", 16'(n), 16'd3);
        cmp("loss_pulse", 16'(bus.lock_lost), 16'd1);
        cmp("loss_pll_rst", 16'(bus.pll_rst), 16'd1);
        cmp("loss_sys_rst", 16'(bus.sys_rst), 16'd1);
        bus.pll_locked = 1'b1;
        @(negedge refclk);
        cmp("loss_pulse_end", 16'(bus.lock_lost), 16'd0);
        wait_for(S_READY, 1'b1, 100, "relock_ready", n);
        cmp("relock_lat", 16'(n), 16'd12);

        // relock_req in RUN, then a one-cycle glitch landing on STABILIZE's last count.
        repeat (3) @(negedge refclk);
        relock_pulse();
        cmp("req_no_lost", 16'(bus.lock_lost), 16'd0);
        cmp("req_ready", 16'(bus.ready), 16'd0);
        wait_for(S_PLL_RST, 1'b0, 50, "req_hold", n);
        cmp("req_hold_len", 16'(n), 16'd4);
        repeat (6) @(negedge refclk);
        bus.pll_locked = 1'b0;
        @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_for(S_READY, 1'b1, 100, "glitch_ready", n);
        cmp("glitch_lat", 16'(n), 16'd11);
        cmp("glitch_retry", 16'(bus.retry_cnt), 16'd0);

        // Lock loss and relock_req reaching the FSM on the same edge.
        repeat (3) @(negedge refclk);
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        bus.relock_req = 1'b1;
        bus.pll_locked = 1'b1;
        @(negedge refclk);
        bus.relock_req = 1'b0;
        pulses = 0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            pulses += int'(bus.lock_lost);
            highs  += int'(bus.pll_rst);
            @(negedge refclk);
        end
        cmp("both_pulses", 16'(pulses), 16'd1);
        cmp("both_hold", 16'(highs), 16'd4);
        cmp("both_ready", 16'(bus.ready), 16'd1);

        // Never lock: three 4-high/16-low attempts, relock_req ignored in WAIT_LOCK.
        bus.pll_locked = 1'b0;
        wait_for(S_LOST, 1'b1, 20, "nolock_lost", n);
        cmp("nolock_lost_lat", 16'(n), 16'd3);
        repeat (6) @(negedge refclk);
        relock_pulse();
        cmp("wait_req_ignored", 16'(bus.pll_rst), 16'd0);
        repeat (18) @(negedge refclk);
        cmp("retry_1", 16'(bus.retry_cnt), 16'd1);
        repeat (20) @(negedge refclk);
        cmp("retry_2", 16'(bus.retry_cnt), 16'd2);
        wait_for(S_FAULT, 1'b1, 100, "fault_entry", n);
        cmp("fault_lat", 16'(n), 16'd15);
        cmp("fault_pll_rst", 16'(bus.pll_rst), 16'd1);
        cmp("fault_sys_rst", 16'(bus.sys_rst), 16'd1);
        cmp("fault_retry", 16'(bus.retry_cnt), 16'd2);
        repeat (5) @(negedge refclk);
        cmp("fault_held", 16'(bus.fault), 16'd1);
        relock_pulse();
        cmp("fault_exit", 16'(bus.fault), 16'd0);
        cmp("fault_exit_retry", 16'(bus.retry_cnt), 16'd0);
        cmp("fault_exit_hold", 16'(bus.pll_rst), 16'd1);

        // rst in WAIT_LOCK at cnt=10, then a full hold interval again.
        repeat (14) @(negedge refclk);
        cmp("mid_in_wait", 16'(bus.pll_rst), 16'd0);
        rst = 1'b1;
        @(negedge refclk);
        cmp("mid_pll_rst", 16'(bus.pll_rst), 16'd1);
        cmp("mid_sys_rst", 16'(bus.sys_rst), 16'd1);
        rst = 1'b0;
        wait_for(S_PLL_RST, 1'b0, 50, "mid_hold", n);
        cmp("mid_hold_len", 16'(n), 16'd4);
        bus.pll_locked = 1'b1;
        wait_for(S_READY, 1'b1, 100, "final_ready", n);
        repeat (2) @(negedge refclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
